// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: register file, control decode, branch/jump redirect, load-use stall, ID/EX register
module instruction_decode #(
    parameter int PC_W = 10,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Instruction,
    input  logic [PC_W-1:0] PCNextReg,
    input  logic            RegWrite_WB,
    input  logic [4:0]      WriteReg_WB,
    input  logic [31:0]     WriteData_WB,
    input  logic            MemRead_EX,
    input  logic [4:0]      Rt_EX,
    output logic [PC_W-1:0] PCJump,
    output logic            PCSrc,
    output logic            Stall,
    output logic [31:0]     ReadData1,
    output logic [31:0]     ReadData2,
    output logic [31:0]     SignExtImm,
    output logic [4:0]      Rs,
    output logic [4:0]      Rt,
    output logic [4:0]      Rd,
    output logic [PC_W-1:0] PCNextID,
    output logic            RegDst,
    output logic            ALUSrc,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemToReg,
    output logic [1:0]      ALUOp,
    output logic [5:0]      Funct
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [31:0] regs [NREG];

    logic [5:0]  opcode;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [31:0] imm_ext;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        c_regdst;
    logic        c_alusrc;
    logic        c_memtoreg;
    logic        c_regwrite;
    logic        c_memread;
    logic        c_memwrite;
    logic [1:0]  c_aluop;

    logic        uses_rt;
    logic        branch_taken;

    assign opcode  = Instruction[31:26];
    assign rs_f    = Instruction[25:21];
    assign rt_f    = Instruction[20:16];
    assign rd_f    = Instruction[15:11];
    assign imm_ext = {{16{Instruction[15]}}, Instruction[15:0]};

    // Register file write port; register 0 is never written so it reads as 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite_WB && (WriteReg_WB != 5'd0)) begin
            regs[WriteReg_WB] <= WriteData_WB;
        end
    end

    // Combinational read ports with same-cycle write-back bypass
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs_f != 5'd0) begin
            rd1 = (RegWrite_WB && (WriteReg_WB == rs_f)) ? WriteData_WB : regs[rs_f];
        end
        if (rt_f != 5'd0) begin
            rd2 = (RegWrite_WB && (WriteReg_WB == rt_f)) ? WriteData_WB : regs[rt_f];
        end
    end

    // Main control decode; unlisted opcodes and j decode as a bubble
    always_comb begin
        c_regdst   = 1'b0;
        c_alusrc   = 1'b0;
        c_memtoreg = 1'b0;
        c_regwrite = 1'b0;
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_aluop    = 2'b00;
        uses_rt    = 1'b0;
        case (opcode)
            OP_R: begin
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
                c_aluop    = 2'b10;
                uses_rt    = 1'b1;
            end
            OP_LW: begin
                c_alusrc   = 1'b1;
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
                c_memread  = 1'b1;
            end
            OP_SW: begin
                c_alusrc   = 1'b1;
                c_memwrite = 1'b1;
                uses_rt    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c_aluop    = 2'b01;
                uses_rt    = 1'b1;
            end
            OP_ADDI: begin
                c_alusrc   = 1'b1;
                c_regwrite = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                c_alusrc   = 1'b1;
                c_regwrite = 1'b1;
                c_aluop    = 2'b11;
            end
            default: ;
        endcase
    end

    // Load-use hazard: rs always counts, rt only for opcodes that read it as a source
    always_comb begin
        Stall = reset && MemRead_EX && (Rt_EX != 5'd0) &&
                ((Rt_EX == rs_f) || ((Rt_EX == rt_f) && uses_rt));
    end

    // Branch resolution and fetch redirect; a stall suppresses any redirect
    always_comb begin
        branch_taken = ((opcode == OP_BEQ) && (rd1 == rd2)) ||
                       ((opcode == OP_BNE) && (rd1 != rd2));
        PCSrc  = 1'b0;
        PCJump = '0;
        if (reset && !Stall) begin
            if (branch_taken) begin
                PCSrc  = 1'b1;
                PCJump = PCNextReg + imm_ext[PC_W-1:0];
            end else if (opcode == OP_J) begin
                PCSrc  = 1'b1;
                PCJump = Instruction[PC_W-1:0];
            end
        end
    end

    // ID/EX pipeline register on the falling edge, controls bubbled while stalled
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ReadData1  <= '0;
            ReadData2  <= '0;
            SignExtImm <= '0;
            Rs         <= '0;
            Rt         <= '0;
            Rd         <= '0;
            PCNextID   <= '0;
            Funct      <= '0;
            RegDst     <= 1'b0;
            ALUSrc     <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            RegWrite   <= 1'b0;
            MemToReg   <= 1'b0;
            ALUOp      <= 2'b00;
        end else begin
            ReadData1  <= rd1;
            ReadData2  <= rd2;
            SignExtImm <= imm_ext;
            Rs         <= rs_f;
            Rt         <= rt_f;
            Rd         <= rd_f;
            PCNextID   <= PCNextReg;
            Funct      <= Instruction[5:0];
            RegDst     <= Stall ? 1'b0 : c_regdst;
            ALUSrc     <= Stall ? 1'b0 : c_alusrc;
            MemRead    <= Stall ? 1'b0 : c_memread;
            MemWrite   <= Stall ? 1'b0 : c_memwrite;
            RegWrite   <= Stall ? 1'b0 : c_regwrite;
            MemToReg   <= Stall ? 1'b0 : c_memtoreg;
            ALUOp      <= Stall ? 2'b00 : c_aluop;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - self-checking bench for instruction_decode
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [9:0]  PCNextReg;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData_WB;
    logic        MemRead_EX;
    logic [4:0]  Rt_EX;
    logic [9:0]  PCJump;
    logic        PCSrc;
    logic        Stall;
    logic [31:0] ReadData1, ReadData2, SignExtImm;
    logic [4:0]  Rs, Rt, Rd;
    logic [9:0]  PCNextID;
    logic        RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_regs [32];

    instruction_decode #(.PC_W(10), .NREG(32)) dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .PCNextReg(PCNextReg),
        .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .PCJump(PCJump), .PCSrc(PCSrc), .Stall(Stall),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtImm(SignExtImm),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .PCNextID(PCNextID),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUOp(ALUOp), .Funct(Funct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control word from the decode table: {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,ALUOp}
    function automatic logic [7:0] ref_ctl(input logic [5:0] op);
        case (op)
            6'd0:  return 8'b1_0_0_1_0_0_10;
            6'd35: return 8'b0_1_1_1_1_0_00;
            6'd43: return 8'b0_1_0_0_0_1_00;
            6'd4, 6'd5: return 8'b0_0_0_0_0_0_01;
            6'd8:  return 8'b0_1_0_1_0_0_00;
            6'd12, 6'd13, 6'd10: return 8'b0_1_0_1_0_0_11;
            default: return 8'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && wr == r) return wd;
        return model_regs[r];
    endfunction

    // One decode step: drive just after a falling edge, check combinational outputs,
    // then check the ID/EX register after the next falling edge.
    task automatic step(input logic [31:0] ins, input logic [9:0] pcn, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd,
                        input logic mre, input logic [4:0] rte);
        logic [5:0]  op;
        logic [31:0] v1, v2, imm;
        logic        rt_src, exp_stall, exp_src;
        int          exp_jump;
        op  = ins[31:26];
        v1  = ref_read(ins[25:21], we, wr, wd);
        v2  = ref_read(ins[20:16], we, wr, wd);
        imm = {{16{ins[15]}}, ins[15:0]};
        rt_src    = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        exp_stall = mre && (rte != 0) &&
                    ((rte == ins[25:21]) || (rt_src && rte == ins[20:16]));
        exp_src  = 1'b0;
        exp_jump = 0;
        if (!exp_stall) begin
            if ((op == 6'd4 && v1 == v2) || (op == 6'd5 && v1 != v2)) begin
                exp_src  = 1'b1;
                exp_jump = (int'(pcn) + int'(imm[9:0])) % 1024;
            end else if (op == 6'd2) begin
                exp_src  = 1'b1;
                exp_jump = int'(ins[9:0]);
            end
        end
        Instruction = ins; PCNextReg = pcn;
        RegWrite_WB = we; WriteReg_WB = wr; WriteData_WB = wd;
        MemRead_EX = mre; Rt_EX = rte;
        #2;
        chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
        chk("pcsrc", {31'd0, PCSrc}, {31'd0, exp_src});
        if (exp_src) chk("pcjump", {22'd0, PCJump}, exp_jump);
        @(negedge clk); #1;
        chk("readdata1", ReadData1, v1);
        chk("readdata2", ReadData2, v2);
        chk("signextimm", SignExtImm, imm);
        chk("specifiers", {17'd0, Rs, Rt, Rd}, {17'd0, ins[25:21], ins[20:16], ins[15:11]});
        chk("pcnextid_funct", {16'd0, PCNextID, Funct}, {16'd0, pcn, ins[5:0]});
        chk("controls", {24'd0, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp},
            {24'd0, exp_stall ? 8'd0 : ref_ctl(op)});
        if (we && wr != 0) model_regs[wr] = wd;
    endtask

    function automatic logic [31:0] all_outs();
        return {ReadData1 | ReadData2 | SignExtImm} |
               {Rs, Rt, Rd, PCNextID, Funct, RegDst, ALUSrc, MemRead, MemWrite,
                RegWrite, MemToReg, ALUOp};
    endfunction

    initial begin
        logic [5:0] ops [11];
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2, 6'd63};
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset = 1'b0;
        Instruction = 32'h0800_0155; PCNextReg = 10'd0;
        RegWrite_WB = 1'b0; WriteReg_WB = 5'd0; WriteData_WB = 32'd0;
        MemRead_EX = 1'b0; Rt_EX = 5'd0;
        #3;
        chk("reset_outputs", all_outs(), 32'd0);
        chk("reset_comb", {22'd0, PCJump} | {31'd0, PCSrc} | {31'd0, Stall}, 32'd0);
        @(negedge clk); #2;
        reset = 1'b1;
        @(negedge clk); #1;

        // Write-back bypass into same-cycle read of rs=5 (addi $1,$5,7)
        step({6'd8, 5'd5, 5'd1, 16'd7}, 10'd3, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        chk("wb_bypass", ReadData1, 32'hDEADBEEF);

        // Register 0 ignores writes
        step(32'd0, 10'd4, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        step({6'd0, 5'd0, 5'd0, 5'd1, 11'h020}, 10'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("reg0_rd1", ReadData1, 32'd0);
        chk("reg0_rd2", ReadData2, 32'd0);

        // Taken beq with wrapping target
        step({6'd4, 5'd3, 5'd3, 16'hFFFE}, 10'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("beq_wrap", {22'd0, PCJump}, 32'h3FF);

        // Load-use hazard on rs: add $9,$8,$2
        step({6'd0, 5'd8, 5'd2, 5'd9, 11'h020}, 10'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        chk("loaduse_stall", {31'd0, Stall}, 32'd1);
        chk("loaduse_regwrite", {31'd0, RegWrite}, 32'd0);

        // Jump
        step({6'd2, 16'd0, 10'h155}, 10'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("j_target", {22'd0, PCJump}, 32'h155);
        chk("j_regwrite", {31'd0, RegWrite}, 32'd0);

        // Randomized decode with write-back and hazards
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 10)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            step(ins, 10'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
        end

        // Asynchronous reset between edges, then confirm registers were cleared
        step({6'd8, 5'd0, 5'd6, 16'd1}, 10'd9, 1'b1, 5'd6, 32'hCAFE0001, 1'b0, 5'd0);
        Instruction = 32'h0800_0155; RegWrite_WB = 1'b0; MemRead_EX = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'd0);
        chk("async_reset_comb", {22'd0, PCJump} | {31'd0, PCSrc} | {31'd0, Stall}, 32'd0);
        #1 reset = 1'b1;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        @(negedge clk); #1;
        step({6'd0, 5'd6, 5'd5, 5'd1, 11'h020}, 10'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("post_reset_rd1", ReadData1, 32'd0);
        chk("post_reset_rd2", ReadData2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter: PC_W, 10, width of the word-addressed program counter.
REQ-002 Parameter: NREG, 32, number of general registers; index width is 5.
REQ-003 Port: clk  in  1  single clock; every register in the block is clocked by clk.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: Instruction  in  32  fetched instruction from the fetch stage.
REQ-006 Port: PCNextReg  in  PC_W  fetch-stage PC+1 paired with Instruction.
REQ-007 Port: RegWrite_WB, WriteReg_WB, WriteData_WB  in  1/5/32  write-back request.
REQ-008 Port: MemRead_EX, Rt_EX  in  1/5  load-in-EX indication and its destination.
REQ-009 Port: PCJump  out  PC_W  redirect target to fetch, combinational.
REQ-010 Port: PCSrc  out  1  redirect select to fetch, combinational.
REQ-011 Port: Stall  out  1  load-use hazard indicator, combinational.
REQ-012 Port: ReadData1, ReadData2, SignExtImm  out  32 each  registered ID/EX operands.
REQ-013 Port: Rs, Rt, Rd  out  5 each  registered register specifiers.
REQ-014 Port: PCNextID  out  PC_W  registered copy of PCNextReg.
REQ-015 Port: RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg  out  1 each  registered controls.
REQ-016 Port: ALUOp  out  2  registered; Funct  out  6  registered Instruction[5:0].

Function
REQ-017 The ID/EX output register SHALL update on the falling edge of clk, matching the fetch stage's edge.
REQ-018 The register file SHALL hold NREG x 32 bits and SHALL be written on the rising edge of clk when RegWrite_WB=1 and WriteReg_WB!=0.
REQ-019 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-020 Reads SHALL be combinational on Instruction[25:21] and [20:16], with bypass: a matching same-cycle write-back SHALL return WriteData_WB.
REQ-021 Decode table (opcode -> RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp):
- 000000 R: 1,0,0,1,0,0,10
- 100011 lw: 0,1,1,1,1,0,00
- 101011 sw: 0,1,0,0,0,1,00
- 000100 beq / 000101 bne: all 0, ALUOp 01
- 001000 addi: 0,1,0,1,0,0,00
- 001100 andi / 001101 ori / 001010 slti: 0,1,0,1,0,0,11
- 000010 j and any unlisted opcode: all 0, ALUOp 00 (bubble).
REQ-022 SignExtImm SHALL be Instruction[15:0] sign-extended to 32 bits.
REQ-023 Branch compare SHALL use the bypassed register values: beq is taken when they are equal; bne is taken when they differ.
REQ-024 A taken branch SHALL drive PCSrc=1 and PCJump=PCNextReg+SignExtImm[PC_W-1:0], modulo 2^PC_W (wraps).
REQ-025 j SHALL drive PCSrc=1 and PCJump=Instruction[PC_W-1:0]; otherwise PCSrc=0 and PCJump=0.
REQ-026 Stall=1 iff all of the following hold:
- MemRead_EX=1 and Rt_EX!=0;
- Rt_EX==Instruction[25:21], or Rt_EX==Instruction[20:16] with an opcode of R, beq, bne or sw.
REQ-027 While Stall=1, the ID/EX controls SHALL be loaded as a bubble (all control outputs 0) and PCSrc SHALL be forced to 0; data fields load normally.
REQ-028 Latency SHALL be one falling edge from Instruction/PCNextReg to the ID/EX outputs.
REQ-029 Simultaneous write-back and stall SHALL both take effect; the write SHALL NOT be suppressed.

Reset
REQ-030 When reset=0, the block SHALL immediately clear all ID/EX outputs and all registers to 0, independent of clk.
REQ-031 Reset deassertion mid-operation SHALL resume decoding at the next falling edge, with no spurious write.
REQ-032 While reset=0, PCJump, PCSrc and Stall SHALL be 0.

Verification
REQ-033 Write-back test:
- Stimulus: RegWrite_WB=1, WriteReg_WB=5, WriteData_WB=0xDEADBEEF, with the same cycle's Instruction reading rs=5.
- Response: ReadData1=0xDEADBEEF after the falling edge.
REQ-034 Register 0 test:
- Stimulus: write 0x1234 to reg 0, then add $1,$0,$0.
- Response: ReadData1=ReadData2=0.
REQ-035 Taken-branch test:
- Stimulus: beq with equal operands, imm=0xFFFE, PCNextReg=1.
- Response: PCSrc=1, PCJump=0x3FF (wrap-around).
REQ-036 Load-use test:
- Stimulus: MemRead_EX=1, Rt_EX=8, Instruction add $9,$8,$2.
- Response: Stall=1, next ID/EX controls all 0, PCSrc=0.
REQ-037 Jump test:
- Stimulus: j with Instruction[9:0]=0x155.
- Response: PCSrc=1, PCJump=0x155, RegWrite=0.
REQ-038 Asynchronous reset test:
- Stimulus: pull reset low between clock edges.
- Response: outputs 0 before the next edge, and register reads return 0 after release.
